// File: rtl/input_conditioner_if.sv
// Bundle between the raw button/switch bank and the conditioned outputs of input_conditioner.
// The master side drives raw_in; the slave side (the conditioner) drives everything else.
interface input_conditioner_if;
  logic [7:0] raw_in;
  logic [7:0] level_out;
  logic [7:0] rise_out;
  logic [7:0] fall_out;
  logic       pause_pulse;
  logic       resume_pulse;
  logic [2:0] speed;

  modport master (
    output raw_in,
    input  level_out, rise_out, fall_out, pause_pulse, resume_pulse, speed
  );

  modport slave (
    input  raw_in,
    output level_out, rise_out, fall_out, pause_pulse, resume_pulse, speed
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronises, debounces and edge-detects the 8-bit ui_in bank, then derives the
// pause/resume request pulses and the 1..6 speed code consumed by speed_controller.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int STICKY_SPEED    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input_conditioner_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // Code of the highest set bit of v (bit0 -> 1 ... bit5 -> 6), or dflt when v is empty.
  function automatic logic [2:0] top_code(input logic [5:0] v, input logic [2:0] dflt);
    logic [2:0] code;
    code = dflt;
    for (int b = 0; b < 6; b++) begin
      if (v[b]) begin
        code = 3'(b + 1);
      end
    end
    return code;
  endfunction

  logic [7:0]       s1_q, s1_d;
  logic [7:0]       s2_q, s2_d;
  logic [7:0]       level_q, level_d;
  logic [7:0]       rise_q, rise_d;
  logic [7:0]       fall_q, fall_d;
  logic             pause_q, pause_d;
  logic             resume_q, resume_d;
  logic [2:0]       speed_q, speed_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];

  // Plain two-flop synchroniser path; nothing but wires between the stages.
  always_comb begin
    s1_d = bus.raw_in;
    s2_d = s1_q;
  end

  // Per-bit debounce: a mismatch must persist for DEBOUNCE_CYCLES edges to be accepted.
  always_comb begin
    level_d = level_q;
    rise_d  = 8'h00;
    fall_d  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = CNT_ZERO;
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = s2_q[i];
          rise_d[i]  = s2_q[i];
          fall_d[i]  = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else begin
        cnt_d[i] = CNT_ZERO;
      end
    end
    // Pause wins when both buttons are accepted on the same edge.
    pause_d  = rise_d[0];
    resume_d = rise_d[1] & ~rise_d[0];
  end

  // Speed is derived from registered pulses/levels, so it lags them by one edge.
  always_comb begin
    speed_d = speed_q;
    if (STICKY_SPEED != 0) begin
      speed_d = top_code(rise_q[7:2], speed_q);
    end else begin
      speed_d = top_code({level_q[7:3], 1'b0}, 3'd1);
    end
  end

  // State registers; async reset clears everything and parks speed at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 8'h00;
      s2_q     <= 8'h00;
      level_q  <= 8'h00;
      rise_q   <= 8'h00;
      fall_q   <= 8'h00;
      pause_q  <= 1'b0;
      resume_q <= 1'b0;
      speed_q  <= 3'd1;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      pause_q  <= pause_d;
      resume_q <= resume_d;
      speed_q  <= speed_d;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.level_out    = level_q;
  assign bus.rise_out     = rise_q;
  assign bus.fall_out     = fall_q;
  assign bus.pause_pulse  = pause_q;
  assign bus.resume_pulse = resume_q;
  assign bus.speed        = speed_q;

endmodule
